// File: rtl/result_display_formatter_pkg.sv
// Shared definitions for the result display formatter: FSM states and active-low 7-seg patterns.
package result_display_formatter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StEncode = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low.
    localparam logic [6:0] SEG_D0 = 7'b1000000;
    localparam logic [6:0] SEG_D1 = 7'b1111001;
    localparam logic [6:0] SEG_D2 = 7'b0100100;
    localparam logic [6:0] SEG_D3 = 7'b0110000;
    localparam logic [6:0] SEG_D4 = 7'b0011001;
    localparam logic [6:0] SEG_D5 = 7'b0010010;
    localparam logic [6:0] SEG_D6 = 7'b0000010;
    localparam logic [6:0] SEG_D7 = 7'b1111000;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0010000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/result_display_formatter_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD codes blank the digit.
module result_display_formatter_seg7_decoder
    import result_display_formatter_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = bcd_to_seg(i_bcd);
    end

endmodule

// File: rtl/result_display_formatter.sv
// Converts one signed result to sign/magnitude BCD by serial double-dabble and drives two
// 7-segment digits plus sign and overflow LEDs; all outputs are registered.
module result_display_formatter
    import result_display_formatter_pkg::*;
#(
    parameter int unsigned IN_W    = 6,
    parameter bit          BLANK_Z = 1'b1
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            RES_VALID,
    output logic            RES_READY,
    input  logic [IN_W-1:0] RES_DATA,
    output logic [6:0]      HEX1,
    output logic [6:0]      HEX0,
    output logic            NEG_LED,
    output logic            OVF_LED,
    output logic            DISP_VALID
);

    localparam int unsigned   CNT_W    = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_t            r_state;
    logic [9:0]        r_bcd;
    logic [IN_W-1:0]   r_mag;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sign;
    logic              r_nonzero;
    logic              r_ready;
    logic              r_disp_valid;
    logic [6:0]        r_hex1;
    logic [6:0]        r_hex0;
    logic              r_neg;
    logic              r_ovf;

    logic              w_accept;
    logic [IN_W-1:0]   w_mag_in;
    logic [3:0]        w_ones_adj;
    logic [3:0]        w_tens_adj;
    logic [6:0]        w_seg_tens;
    logic [6:0]        w_seg_ones;

    assign w_accept   = RES_VALID && r_ready;
    // Unsigned negate: the most negative input maps to 2^(IN_W-1) without clamping.
    assign w_mag_in   = RES_DATA[IN_W-1] ? -RES_DATA : RES_DATA;
    assign w_ones_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    assign w_tens_adj = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];

    result_display_formatter_seg7_decoder u_seg_tens (
        .i_bcd (r_bcd[7:4]),
        .o_seg (w_seg_tens)
    );

    result_display_formatter_seg7_decoder u_seg_ones (
        .i_bcd (r_bcd[3:0]),
        .o_seg (w_seg_ones)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= StIdle;
            r_bcd        <= '0;
            r_mag        <= '0;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_nonzero    <= 1'b0;
            r_ready      <= 1'b0;
            r_disp_valid <= 1'b0;
            r_hex1       <= SEG_BLANK;
            r_hex0       <= SEG_BLANK;
            r_neg        <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_sign    <= RES_DATA[IN_W-1];
                        r_nonzero <= |RES_DATA;
                        r_mag     <= w_mag_in;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    // Adjust, then shift {hund,tens,ones,mag} left by one; hundreds needs no adjust.
                    r_bcd   <= {r_bcd[8], w_tens_adj, w_ones_adj, r_mag[IN_W-1]};
                    r_mag   <= r_mag << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= StEncode;
                    end
                end
                StEncode: begin
                    if (r_bcd[9:8] != 2'd0) begin
                        r_ovf  <= 1'b1;
                        r_hex1 <= SEG_DASH;
                        r_hex0 <= SEG_DASH;
                    end else begin
                        r_ovf  <= 1'b0;
                        r_hex0 <= w_seg_ones;
                        r_hex1 <= (BLANK_Z && (r_bcd[7:4] == 4'd0)) ? SEG_BLANK : w_seg_tens;
                    end
                    r_neg        <= r_sign && r_nonzero;
                    r_disp_valid <= 1'b1;
                    r_ready      <= 1'b1;
                    r_state      <= StIdle;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign RES_READY  = r_ready;
    assign DISP_VALID = r_disp_valid;
    assign HEX1       = r_hex1;
    assign HEX0       = r_hex0;
    assign NEG_LED    = r_neg;
    assign OVF_LED    = r_ovf;

endmodule

// File: tb/tb_result_display_formatter.sv
// Bench for result_display_formatter: three instances (6-bit blanking, 6-bit leading zero,
// 8-bit) checked against a decimal arithmetic reference model.
module tb_result_display_formatter;

    logic       clk;
    logic       rst_n;

    logic       a_valid, a_ready, a_neg, a_ovf, a_dv;
    logic [5:0] a_data;
    logic [6:0] a_hex1, a_hex0;
    logic       b_valid, b_ready, b_neg, b_ovf, b_dv;
    logic [5:0] b_data;
    logic [6:0] b_hex1, b_hex0;
    logic       c_valid, c_ready, c_neg, c_ovf, c_dv;
    logic [7:0] c_data;
    logic [6:0] c_hex1, c_hex0;

    int n_cmp = 0;
    int n_bad = 0;

    result_display_formatter #(.IN_W(6), .BLANK_Z(1'b1)) u_dut_a (
        .CLOCK_50 (clk), .RESET_N (rst_n), .RES_VALID (a_valid), .RES_READY (a_ready),
        .RES_DATA (a_data), .HEX1 (a_hex1), .HEX0 (a_hex0), .NEG_LED (a_neg),
        .OVF_LED (a_ovf), .DISP_VALID (a_dv)
    );

    result_display_formatter #(.IN_W(6), .BLANK_Z(1'b0)) u_dut_b (
        .CLOCK_50 (clk), .RESET_N (rst_n), .RES_VALID (b_valid), .RES_READY (b_ready),
        .RES_DATA (b_data), .HEX1 (b_hex1), .HEX0 (b_hex0), .NEG_LED (b_neg),
        .OVF_LED (b_ovf), .DISP_VALID (b_dv)
    );

    result_display_formatter #(.IN_W(8), .BLANK_Z(1'b1)) u_dut_c (
        .CLOCK_50 (clk), .RESET_N (rst_n), .RES_VALID (c_valid), .RES_READY (c_ready),
        .RES_DATA (c_data), .HEX1 (c_hex1), .HEX0 (c_hex0), .NEG_LED (c_neg),
        .OVF_LED (c_ovf), .DISP_VALID (c_dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of |value| via division, looked up in the display table.
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Packed {hex1, hex0, neg, ovf, ready} as seen in the DISP_VALID cycle.
    function automatic logic [16:0] model(input int value, input bit blank);
        int mag;
        logic [6:0] h1, h0;
        mag = (value < 0) ? -value : value;
        if (mag > 99) begin
            h1 = 7'b0111111;
            h0 = 7'b0111111;
        end else begin
            h0 = seg(mag % 10);
            h1 = (blank && mag < 10) ? 7'h7F : seg(mag / 10);
        end
        return {h1, h0, (value < 0), (mag > 99), 1'b1};
    endfunction

    function automatic logic rdy(input int w);
        case (w)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    function automatic logic dv(input int w);
        case (w)
            0: return a_dv;
            1: return b_dv;
            default: return c_dv;
        endcase
    endfunction

    function automatic logic [16:0] outs(input int w);
        case (w)
            0: return {a_hex1, a_hex0, a_neg, a_ovf, a_ready};
            1: return {b_hex1, b_hex0, b_neg, b_ovf, b_ready};
            default: return {c_hex1, c_hex0, c_neg, c_ovf, c_ready};
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input int value);
        case (w)
            0: begin a_valid = v; a_data = 6'(value); end
            1: begin b_valid = v; b_data = 6'(value); end
            default: begin c_valid = v; c_data = 8'(value); end
        endcase
    endtask

    // Presents one value, returns posedges from accept to DISP_VALID, pulse width and outputs.
    task automatic run_conv(input int w, input int value, output int lat, output int dv_w,
                            output logic [16:0] got);
        int t;
        lat = -1;
        dv_w = 0;
        got = '0;
        @(negedge clk);
        t = 0;
        while (!rdy(w) && t < 40) begin
            @(negedge clk);
            t++;
        end
        set_in(w, 1'b1, value);
        @(negedge clk);
        set_in(w, 1'b0, 0);
        for (int j = 0; j < 40 && lat < 0; j++) begin
            if (dv(w)) begin
                lat = j;
                got = outs(w);
            end else begin
                @(negedge clk);
            end
        end
        while (dv(w) && dv_w < 5) begin
            dv_w++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        a_valid = 0; a_data = '0; b_valid = 0; b_data = '0; c_valid = 0; c_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_hex1, a_hex0, a_neg, a_ovf, a_dv} !== {7'h7F, 7'h7F, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_a outs got %b want %b", {a_hex1, a_hex0, a_neg, a_ovf, a_dv},
                     {7'h7F, 7'h7F, 3'b000});
        end
        n_cmp++;
        if ({c_hex1, c_hex0, c_neg, c_ovf, c_dv} !== {7'h7F, 7'h7F, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_c outs got %b want %b", {c_hex1, c_hex0, c_neg, c_ovf, c_dv},
                     {7'h7F, 7'h7F, 3'b000});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 111", {a_ready, b_ready, c_ready});
        end
        n_cmp++;
        if ({a_hex1, a_hex0, a_dv} !== {7'h7F, 7'h7F, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_after_release got %b want blank", {a_hex1, a_hex0, a_dv});
        end
    endtask

    task automatic test_directed();
        int lat, dv_w;
        logic [16:0] got;
        int vals_a[4] = '{16, -9, 0, -32};
        int vals_b[2] = '{-9, 0};
        int vals_c[4] = '{-128, 99, 100, -100};
        foreach (vals_a[i]) begin
            run_conv(0, vals_a[i], lat, dv_w, got);
            n_cmp++;
            if (got !== model(vals_a[i], 1'b1) || lat !== 7 || dv_w !== 1) begin
                n_bad++;
                $display("FAIL directed_a v=%0d got %b lat %0d w %0d want %b lat 7 w 1",
                         vals_a[i], got, lat, dv_w, model(vals_a[i], 1'b1));
            end
        end
        foreach (vals_b[i]) begin
            run_conv(1, vals_b[i], lat, dv_w, got);
            n_cmp++;
            if (got !== model(vals_b[i], 1'b0) || lat !== 7 || dv_w !== 1) begin
                n_bad++;
                $display("FAIL leading_zero v=%0d got %b lat %0d w %0d want %b lat 7 w 1",
                         vals_b[i], got, lat, dv_w, model(vals_b[i], 1'b0));
            end
        end
        foreach (vals_c[i]) begin
            run_conv(2, vals_c[i], lat, dv_w, got);
            n_cmp++;
            if (got !== model(vals_c[i], 1'b1) || lat !== 9 || dv_w !== 1) begin
                n_bad++;
                $display("FAIL wide v=%0d got %b lat %0d w %0d want %b lat 9 w 1",
                         vals_c[i], got, lat, dv_w, model(vals_c[i], 1'b1));
            end
        end
    endtask

    task automatic test_random();
        int lat, dv_w, v, w;
        logic [16:0] got;
        for (int i = 0; i < 60; i++) begin
            w = i % 3;
            v = (w == 2) ? int'($urandom_range(255)) - 128 : int'($urandom_range(63)) - 32;
            run_conv(w, v, lat, dv_w, got);
            n_cmp++;
            if (got !== model(v, (w != 1)) || lat !== ((w == 2) ? 9 : 7) || dv_w !== 1) begin
                n_bad++;
                $display("FAIL random dut%0d v=%0d got %b lat %0d w %0d want %b", w, v, got,
                         lat, dv_w, model(v, (w != 1)));
            end
        end
    endtask

    task automatic test_ignored();
        int lat, dv_w, t;
        logic [16:0] got;
        logic spurious;
        @(negedge clk);
        t = 0;
        while (!a_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        set_in(0, 1'b1, 16);
        @(negedge clk);
        set_in(0, 1'b0, 0);
        repeat (2) @(negedge clk);
        set_in(0, 1'b1, 5);
        n_cmp++;
        if (a_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_busy_ready got %b want 0", a_ready);
        end
        @(negedge clk);
        set_in(0, 1'b0, 0);
        lat = -1;
        got = '0;
        for (int j = 3; j < 40 && lat < 0; j++) begin
            if (a_dv) begin
                lat = j;
                got = outs(0);
            end else begin
                @(negedge clk);
            end
        end
        n_cmp++;
        if (got !== model(16, 1'b1) || lat !== 7) begin
            n_bad++;
            $display("FAIL ignored_first got %b lat %0d want %b lat 7", got, lat,
                     model(16, 1'b1));
        end
        spurious = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (a_dv) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_not_queued extra DISP_VALID got %b want 0", spurious);
        end
        run_conv(0, 5, lat, dv_w, got);
        n_cmp++;
        if (got !== model(5, 1'b1) || lat !== 7) begin
            n_bad++;
            $display("FAIL ignored_retry got %b lat %0d want %b lat 7", got, lat,
                     model(5, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        int first_dv, second_dv;
        logic [16:0] got;
        first_dv = -1;
        second_dv = -1;
        got = '0;
        @(negedge clk);
        set_in(0, 1'b1, 16);
        @(negedge clk);
        set_in(0, 1'b1, -9);
        for (int j = 0; j < 30; j++) begin
            if (j == 8) set_in(0, 1'b0, 0);
            if (a_dv) begin
                if (first_dv < 0) first_dv = j;
                else begin
                    second_dv = j;
                    got = outs(0);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (first_dv !== 7 || second_dv !== 15) begin
            n_bad++;
            $display("FAIL back_to_back timing got %0d,%0d want 7,15", first_dv, second_dv);
        end
        n_cmp++;
        if (got !== model(-9, 1'b1)) begin
            n_bad++;
            $display("FAIL back_to_back second got %b want %b", got, model(-9, 1'b1));
        end
    endtask

    task automatic test_midreset();
        int lat, dv_w;
        logic [16:0] got;
        logic saw_dv;
        run_conv(0, 16, lat, dv_w, got);
        set_in(0, 1'b1, -9);
        @(posedge clk);
        #1 set_in(0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_hex1, a_hex0, a_neg, a_ovf, a_dv} !== {7'h7F, 7'h7F, 3'b000}) begin
            n_bad++;
            $display("FAIL midreset_blank got %b want %b", {a_hex1, a_hex0, a_neg, a_ovf, a_dv},
                     {7'h7F, 7'h7F, 3'b000});
        end
        saw_dv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_dv) saw_dv = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (a_dv) saw_dv = 1'b1;
        n_cmp++;
        if ({a_ready, saw_dv, a_hex1} !== {1'b1, 1'b0, 7'h7F}) begin
            n_bad++;
            $display("FAIL midreset_release got ready %b dv %b hex1 %b want 1 0 1111111",
                     a_ready, saw_dv, a_hex1);
        end
        run_conv(0, -9, lat, dv_w, got);
        n_cmp++;
        if (got !== model(-9, 1'b1) || lat !== 7 || dv_w !== 1) begin
            n_bad++;
            $display("FAIL midreset_next got %b lat %0d want %b lat 7", got, lat,
                     model(-9, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored();
        test_back_to_back();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
